cmp_seq_arbiter: RTL and testbench

//  Sequential magnitude-compare engine shared by two requesters. One 1-bit compare

---
 rtl/cmp_seq_arbiter_if.sv | 27 ++
 rtl/cmp_seq_arbiter.sv | 120 ++++++++++++
 tb/tb_cmp_seq_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cmp_seq_arbiter_if.sv
// Handshake bundle between two requesters and the shared sequential comparator.
// The master side drives requests and operands; the slave side (the engine) returns grant and results.
interface cmp_seq_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [1:0]       grant;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output req, a0, b0, a1, b1,
        input  grant, busy, done, gt, eq, lt
    );

    modport slave (
        input  req, a0, b0, a1, b1,
        output grant, busy, done, gt, eq, lt
    );
endinterface

// File: rtl/cmp_seq_arbiter.sv
// Round-robin shared bit-serial magnitude comparator, MSB first, one bit per cycle.
// Optional macro CMP_EARLY_EXIT_EN: finish on the first differing bit instead of a fixed WIDTH-cycle scan.
module cmp_seq_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    cmp_seq_arbiter_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [CW-1:0]    cnt_q;
    logic             diff_gt_q, diff_lt_q;
    logic             diff_gt_d, diff_lt_d;
    logic [1:0]       grant_q;
    logic             busy_q, done_q, gt_q, eq_q, lt_q;
    logic             prio_q;
    logic             win1;
    logic             last_bit;

    // prio_q names the requester that wins a tie; it moves away from whoever was just served
    always_comb begin
        win1 = bus.req[1] & (~bus.req[0] | prio_q);
    end

    // Once either flag is set the remaining lower bits can no longer change the outcome
    always_comb begin
        diff_gt_d = diff_gt_q;
        diff_lt_d = diff_lt_q;
        if (!(diff_gt_q || diff_lt_q)) begin
            diff_gt_d = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
            diff_lt_d = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
        end
    end

    always_comb begin
        last_bit = (cnt_q == '0) || (EARLY && (diff_gt_d || diff_lt_d));
    end

    // Operand shift registers carry no reset: they are always loaded before being read
    always_ff @(posedge CLOCK_50) begin
        if (state_q == S_IDLE && bus.req != 2'b00) begin
            sa_q <= win1 ? bus.a1 : bus.a0;
            sb_q <= win1 ? bus.b1 : bus.b0;
        end else if (state_q == S_SHIFT) begin
            sa_q <= sa_q << 1;
            sb_q <= sb_q << 1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            diff_gt_q <= 1'b0;
            diff_lt_q <= 1'b0;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        grant_q   <= win1 ? 2'b10 : 2'b01;
                        busy_q    <= 1'b1;
                        cnt_q     <= CW'(WIDTH - 1);
                        diff_gt_q <= 1'b0;
                        diff_lt_q <= 1'b0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    diff_gt_q <= diff_gt_d;
                    diff_lt_q <= diff_lt_d;
                    cnt_q     <= cnt_q - CW'(1);
                    if (last_bit) begin
                        gt_q    <= diff_gt_d;
                        lt_q    <= diff_lt_d;
                        eq_q    <= ~(diff_gt_d | diff_lt_d);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    prio_q  <= grant_q[0];
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.gt    = gt_q;
    assign bus.eq    = eq_q;
    assign bus.lt    = lt_q;

endmodule

// File: tb/tb_cmp_seq_arbiter.sv
// Directed bench for cmp_seq_arbiter (WIDTH=4): results, latency, round-robin order, reset abort.
module tb_cmp_seq_arbiter;

    localparam int W = 4;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    cmp_seq_arbiter_if #(.WIDTH(W)) bus ();

    cmp_seq_arbiter #(.WIDTH(W)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One transaction: req applied for a single edge, latency counted from the grant edge
    task automatic run_one(input string tag, input logic [1:0] r,
                           input logic [3:0] a0v, input logic [3:0] b0v,
                           input logic [3:0] a1v, input logic [3:0] b1v,
                           input logic [1:0] g, input int lat_full, input int lat_en,
                           input logic [2:0] res, input logic [2:0] prev, input bit mutate);
        int n;
        @(negedge clk);
        bus.req = r; bus.a0 = a0v; bus.b0 = b0v; bus.a1 = a1v; bus.b1 = b1v;
        @(posedge clk); #1;
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check({tag, ".hold"}, 32'({bus.gt, bus.eq, bus.lt}), 32'(prev));
        @(negedge clk);
        bus.req = 2'b00;
        if (mutate) begin
            bus.a0 = 4'd0; bus.b0 = 4'd15; bus.a1 = 4'd0; bus.b1 = 4'd15;
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".lat"}, 32'(n), 32'(EARLY ? lat_en : lat_full));
        check({tag, ".owner"}, 32'(bus.grant), 32'(g));
        check({tag, ".res"}, 32'({bus.gt, bus.eq, bus.lt}), 32'(res));
        @(posedge clk); #1;
        check({tag, ".idle"}, 32'({bus.done, bus.busy, bus.grant}), 32'd0);
        check({tag, ".keep"}, 32'({bus.gt, bus.eq, bus.lt}), 32'(res));
    endtask

    initial begin
        int n;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req = 2'b00; bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset.out", 32'({bus.grant, bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle.noreq", 32'({bus.grant, bus.busy, bus.done}), 32'd0);

        // result triples are {gt,eq,lt}
        run_one("t1_gt",    2'b01, 4'd9, 4'd5, 4'd0, 4'd0, 2'b01, 4, 1, 3'b100, 3'b000, 1'b0);
        run_one("t2_eq",    2'b10, 4'd0, 4'd0, 4'd6, 4'd6, 2'b10, 4, 4, 3'b010, 3'b100, 1'b0);
        run_one("t3_lt",    2'b01, 4'd3, 4'd12, 4'd0, 4'd0, 2'b01, 4, 1, 3'b001, 3'b010, 1'b0);
        run_one("t4_tie1",  2'b11, 4'd2, 4'd0, 4'd8, 4'd9, 2'b10, 4, 4, 3'b001, 3'b001, 1'b0);
        run_one("t5_tie0",  2'b11, 4'd2, 4'd0, 4'd8, 4'd9, 2'b01, 4, 3, 3'b100, 3'b001, 1'b0);
        run_one("t6_latch", 2'b01, 4'd9, 4'd5, 4'd0, 4'd0, 2'b01, 4, 1, 3'b100, 3'b100, 1'b1);

        // Abort a compare mid-scan; operands differ only in the LSB so SHIFT lasts in both builds
        @(negedge clk);
        bus.req = 2'b01; bus.a0 = 4'd1; bus.b0 = 4'd0;
        @(posedge clk); #1;
        check("abort.grant", 32'(bus.grant), 32'd1);
        @(negedge clk);
        bus.req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.out", 32'({bus.grant, bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) n++;
        end
        check("abort.nodone", 32'(n), 32'd0);

        run_one("t7_retry", 2'b11, 4'd3, 4'd12, 4'd7, 4'd7, 2'b01, 4, 1, 3'b001, 3'b000, 1'b0);

        // Both requesters held: grants must alternate starting with requester 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 2'b11; bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (bus.grant === 2'b00 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("rr%0d.gap", i), 32'(n), 32'd1);
            check($sformatf("rr%0d.grant", i), 32'(bus.grant), (i % 2 == 0) ? 32'd1 : 32'd2);
            n = 0;
            while (bus.done !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("rr%0d.lat", i), 32'(n), 32'd4);
            check($sformatf("rr%0d.eq", i), 32'({bus.gt, bus.eq, bus.lt}), 32'b010);
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.req = 2'b00;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
